// File: rtl/sd_sec_arbiter_if.sv
// sd_sec_arbiter_if: bundles the requester-side handshake and the
// sd_card_top sector port that sd_sec_arbiter sits between.
// Modport slave is the arbiter's view.
// Modport master is the view of the user logic plus card (e.g. a testbench).
interface sd_sec_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
);
    // requester side
    logic [1:0]        req;
    logic [1:0]        wr;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        ack;
    logic [1:0]        done;
    logic [1:0]        err;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rvalid;
    logic [1:0]        wreq;
    logic              busy;

    // sd_card_top side
    logic              sd_init_done;
    logic              sd_sec_read;
    logic [ADDR_W-1:0] sd_sec_read_addr;
    logic [DATA_W-1:0] sd_sec_read_data;
    logic              sd_sec_read_data_valid;
    logic              sd_sec_read_end;
    logic              sd_sec_write;
    logic [ADDR_W-1:0] sd_sec_write_addr;
    logic [DATA_W-1:0] sd_sec_write_data;
    logic              sd_sec_write_data_req;
    logic              sd_sec_write_end;

    modport slave (
        input  req, wr, addr0, addr1, wdata0, wdata1,
        input  sd_init_done, sd_sec_read_data, sd_sec_read_data_valid,
        input  sd_sec_read_end, sd_sec_write_data_req, sd_sec_write_end,
        output ack, done, err, rdata, rvalid, wreq, busy,
        output sd_sec_read, sd_sec_read_addr,
        output sd_sec_write, sd_sec_write_addr, sd_sec_write_data
    );

    modport master (
        output req, wr, addr0, addr1, wdata0, wdata1,
        output sd_init_done, sd_sec_read_data, sd_sec_read_data_valid,
        output sd_sec_read_end, sd_sec_write_data_req, sd_sec_write_end,
        input  ack, done, err, rdata, rvalid, wreq, busy,
        input  sd_sec_read, sd_sec_read_addr,
        input  sd_sec_write, sd_sec_write_addr, sd_sec_write_data
    );
endinterface

// File: rtl/sd_sec_arbiter.sv
// sd_sec_arbiter: shares the single sd_card_top sector read/write port
// between two requesters. One owner is granted per 512-byte sector.
// The owner's command is driven to the card, and byte traffic is steered
// to and from the owner only. Losing sd_init_done mid-sector aborts with err.
//
// Build option: define SD_SEC_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
// In the default build (macro undefined), requester 0 has fixed priority.
module sd_sec_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    sd_sec_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_IDLE      = 3'd1,
        S_READ      = 3'd2,
        S_WRITE     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t            state_reg;
    logic              owner_reg;
    logic [1:0]        ack_reg;
    logic [1:0]        done_reg;
    logic [1:0]        err_reg;
    logic              read_reg;
    logic              write_reg;
    logic              busy_reg;
    logic [ADDR_W-1:0] read_addr_reg;
    logic [ADDR_W-1:0] write_addr_reg;

`ifdef SD_SEC_ARB_ROUND_ROBIN_EN
    // requester that most recently completed a sector; starts at 1 so
    // requester 0 wins the first tie
    logic              last_reg;
`endif

    logic              winner_next;
    logic              winner_wr;
    logic [ADDR_W-1:0] winner_addr;
    logic [1:0]        winner_onehot;
    logic [1:0]        owner_onehot;
    logic [1:0]        rvalid_vec;
    logic [1:0]        wreq_vec;
    logic              in_read;
    logic              in_write;

    assign in_read  = (state_reg == S_READ);
    assign in_write = (state_reg == S_WRITE);

    // pick the requester to grant when at least one req bit is set
`ifdef SD_SEC_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner_next = 1'b0;
        if (bus.req == 2'b11) begin
            winner_next = ~last_reg;
        end else begin
            winner_next = bus.req[1];
        end
    end
`else
    always_comb begin
        winner_next = 1'b0;
        // requester 0 wins whenever it asks
        if (!bus.req[0]) begin
            winner_next = 1'b1;
        end
    end
`endif

    assign winner_wr   = bus.wr[winner_next];
    assign winner_addr = winner_next ? bus.addr1 : bus.addr0;

    // per-requester decode and byte steering; the non-owner never sees a strobe
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign winner_onehot[gi] = (winner_next == 1'(gi));
            assign owner_onehot[gi]  = (owner_reg == 1'(gi));
            assign rvalid_vec[gi]    = bus.sd_sec_read_data_valid & in_read & owner_onehot[gi];
            assign wreq_vec[gi]      = bus.sd_sec_write_data_req & in_write & owner_onehot[gi];
        end
    endgenerate

    assign bus.rvalid            = rvalid_vec;
    assign bus.wreq              = wreq_vec;
    assign bus.rdata             = bus.sd_sec_read_data;
    assign bus.sd_sec_write_data = owner_reg ? bus.wdata1 : bus.wdata0;

    assign bus.ack               = ack_reg;
    assign bus.done              = done_reg;
    assign bus.err               = err_reg;
    assign bus.busy              = busy_reg;
    assign bus.sd_sec_read       = read_reg;
    assign bus.sd_sec_write      = write_reg;
    assign bus.sd_sec_read_addr  = read_addr_reg;
    assign bus.sd_sec_write_addr = write_addr_reg;

    // sector ownership FSM with registered grant/command/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_WAIT_INIT;
            owner_reg      <= 1'b0;
            ack_reg        <= 2'b00;
            done_reg       <= 2'b00;
            err_reg        <= 2'b00;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            read_addr_reg  <= '0;
            write_addr_reg <= '0;
`ifdef SD_SEC_ARB_ROUND_ROBIN_EN
            last_reg       <= 1'b1;
`endif
        end else begin
            // status strobes are single-cycle pulses
            ack_reg  <= 2'b00;
            done_reg <= 2'b00;
            err_reg  <= 2'b00;

            case (state_reg)
                S_WAIT_INIT: begin
                    if (bus.sd_init_done) begin
                        state_reg <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (|bus.req) begin
                        // wr and addr are captured only here
                        owner_reg <= winner_next;
                        ack_reg   <= winner_onehot;
                        busy_reg  <= 1'b1;
                        if (winner_wr) begin
                            write_addr_reg <= winner_addr;
                            write_reg      <= 1'b1;
                            state_reg      <= S_WRITE;
                        end else begin
                            read_addr_reg  <= winner_addr;
                            read_reg       <= 1'b1;
                            state_reg      <= S_READ;
                        end
                    end
                end

                S_READ: begin
                    // card loss takes precedence over a coincident end
                    if (!bus.sd_init_done) begin
                        read_reg  <= 1'b0;
                        write_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        err_reg   <= owner_onehot;
                        state_reg <= S_WAIT_INIT;
                    end else if (bus.sd_sec_read_end) begin
                        read_reg  <= 1'b0;
                        done_reg  <= owner_onehot;
                        state_reg <= S_DONE;
                    end
                end

                S_WRITE: begin
                    if (!bus.sd_init_done) begin
                        read_reg  <= 1'b0;
                        write_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        err_reg   <= owner_onehot;
                        state_reg <= S_WAIT_INIT;
                    end else if (bus.sd_sec_write_end) begin
                        write_reg <= 1'b0;
                        done_reg  <= owner_onehot;
                        state_reg <= S_DONE;
                    end
                end

                S_DONE: begin
                    // one settling cycle before the port can be granted again;
                    // an abort here leaves the round-robin history untouched
                    if (!bus.sd_init_done) begin
                        read_reg  <= 1'b0;
                        write_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        err_reg   <= owner_onehot;
                        state_reg <= S_WAIT_INIT;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
`ifdef SD_SEC_ARB_ROUND_ROBIN_EN
                        last_reg  <= owner_reg;
`endif
                    end
                end

                default: begin
                    read_reg  <= 1'b0;
                    write_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_WAIT_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sec_arbiter.sv
// tb_sd_sec_arbiter: randomized bench for sd_sec_arbiter.
// A transaction-level model of the port owner predicts every registered
// output. It is compared each cycle, and directed literal checks pin the model.
module tb_sd_sec_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    sd_sec_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sd_sec_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    // tie-break rule: round-robin gives the tie to whoever did not finish last
    function automatic int pick(input logic [1:0] r, input bit last);
        bit rr = 1'b0;
`ifdef SD_SEC_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`endif
        if (r == 2'b10) return 1;
        if (r == 2'b11) return (rr && !last) ? 1 : 0;
        return 0;
    endfunction

    // ---------------- reference model ----------------
    // m_linked: card usable; m_cur: -1 no sector owned, else owning requester
    // m_tail: the one settling cycle after completion
    bit          m_linked;
    int          m_cur;
    bit          m_write;
    bit          m_tail;
    bit          m_own;
    bit          m_last;
    int          m_win;
    logic [1:0]  e_ack, e_done, e_err;
    logic        e_rd, e_wr, e_busy;
    logic [31:0] e_raddr, e_waddr;
    logic [1:0]  x_rvalid, x_wreq;
    logic [7:0]  x_wdata;

    always_comb m_win = pick(bus.req, m_last);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_linked <= 1'b0; m_cur <= -1; m_write <= 1'b0; m_tail <= 1'b0;
            m_own <= 1'b0; m_last <= 1'b1;
            e_ack <= 2'b00; e_done <= 2'b00; e_err <= 2'b00;
            e_rd <= 1'b0; e_wr <= 1'b0; e_busy <= 1'b0;
            e_raddr <= '0; e_waddr <= '0;
        end else begin
            e_ack <= 2'b00; e_done <= 2'b00; e_err <= 2'b00;
            if (!m_linked) begin
                if (bus.sd_init_done) m_linked <= 1'b1;
            end else if (m_cur < 0) begin
                if (bus.req != 2'b00) begin
                    m_cur   <= m_win;
                    m_own   <= (m_win == 1);
                    m_write <= bus.wr[m_win];
                    e_ack   <= onehot(m_win);
                    e_busy  <= 1'b1;
                    if (bus.wr[m_win]) begin
                        e_wr    <= 1'b1;
                        e_waddr <= (m_win == 1) ? bus.addr1 : bus.addr0;
                    end else begin
                        e_rd    <= 1'b1;
                        e_raddr <= (m_win == 1) ? bus.addr1 : bus.addr0;
                    end
                end
            end else if (!bus.sd_init_done) begin
                e_err <= onehot(m_cur);
                e_rd <= 1'b0; e_wr <= 1'b0; e_busy <= 1'b0;
                m_cur <= -1; m_tail <= 1'b0; m_linked <= 1'b0;
            end else if (m_tail) begin
                m_last <= (m_cur == 1);
                m_cur  <= -1; m_tail <= 1'b0; e_busy <= 1'b0;
            end else if (m_write ? bus.sd_sec_write_end : bus.sd_sec_read_end) begin
                e_done <= onehot(m_cur);
                m_tail <= 1'b1; e_rd <= 1'b0; e_wr <= 1'b0;
            end
        end
    end

    always_comb begin
        x_rvalid = 2'b00;
        x_wreq   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            x_rvalid[i] = bus.sd_sec_read_data_valid && (m_cur == i) && !m_write && !m_tail;
            x_wreq[i]   = bus.sd_sec_write_data_req && (m_cur == i) && m_write && !m_tail;
        end
        x_wdata = m_own ? bus.wdata1 : bus.wdata0;
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        check("ack", bus.ack, e_ack);
        check("done", bus.done, e_done);
        check("err", bus.err, e_err);
        check("sd_sec_read", bus.sd_sec_read, e_rd);
        check("sd_sec_write", bus.sd_sec_write, e_wr);
        check("read_addr", bus.sd_sec_read_addr, e_raddr);
        check("write_addr", bus.sd_sec_write_addr, e_waddr);
        check("busy", bus.busy, e_busy);
        check("rvalid", bus.rvalid, x_rvalid);
        check("wreq", bus.wreq, x_wreq);
        check("rdata", bus.rdata, bus.sd_sec_read_data);
        check("write_data", bus.sd_sec_write_data, x_wdata);
    end

    // strobe counters for per-sector totals
    int c_rv [2] = '{0, 0};
    int c_wq [2] = '{0, 0};
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bus.rvalid[i] === 1'b1) c_rv[i] <= c_rv[i] + 1;
            if (bus.wreq[i] === 1'b1)   c_wq[i] <= c_wq[i] + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [1:0] rq, input logic [1:0] w, input logic [31:0] a0,
                           input logic [31:0] a1, input bit hold, output int winner);
        bit ok;
        ok = 1'b0;
        winner = 0;
        bus.req = rq; bus.wr = w; bus.addr0 = a0; bus.addr1 = a1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (bus.ack !== 2'b00) begin
                ok = 1'b1;
                winner = (bus.ack[1] === 1'b1) ? 1 : 0;
            end
        end
        check("grant_seen", ok, 1'b1);
        tick();
        if (!hold) bus.req = 2'b00;
        // later changes to wr/addr must not matter
        bus.wr = 2'($urandom); bus.addr0 = $urandom; bus.addr1 = $urandom;
    endtask

    // sd_card_top stand-in: moves nbytes, optionally drops init before byte drop_at
    task automatic serve(input int owner, input int nbytes, input int drop_at);
        bit is_wr;
        int rv_b [2];
        int wq_b [2];
        is_wr = (bus.sd_sec_write === 1'b1);
        for (int i = 0; i < 2; i++) begin rv_b[i] = c_rv[i]; wq_b[i] = c_wq[i]; end
        for (int k = 0; k < nbytes; k++) begin
            if (k == drop_at) begin
                bus.sd_init_done = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    if (is_wr) bus.sd_sec_write_end = 1'b1;
                    else bus.sd_sec_read_end = 1'b1;
                end
                tick();
                bus.sd_sec_read_end = 1'b0; bus.sd_sec_write_end = 1'b0;
                @(negedge clk);
                check("abort_err", bus.err, onehot(owner));
                check("abort_done", bus.done, 2'b00);
                check("abort_port", {bus.sd_sec_read, bus.sd_sec_write}, 2'b00);
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                // stray end of the other direction must be ignored
                if ($urandom_range(0, 3) == 0) begin
                    if (is_wr) bus.sd_sec_read_end = 1'b1;
                    else bus.sd_sec_write_end = 1'b1;
                end
                tick();
                bus.sd_sec_read_end = 1'b0; bus.sd_sec_write_end = 1'b0;
            end
            if (is_wr) begin
                bus.sd_sec_write_data_req = 1'b1;
                if (owner == 1) begin bus.wdata1 = k[7:0]; bus.wdata0 = 8'($urandom); end
                else begin bus.wdata0 = k[7:0]; bus.wdata1 = 8'($urandom); end
            end else begin
                bus.sd_sec_read_data_valid = 1'b1;
                bus.sd_sec_read_data = k[7:0];
            end
            tick();
            bus.sd_sec_read_data_valid = 1'b0;
            bus.sd_sec_write_data_req = 1'b0;
        end
        if (is_wr) bus.sd_sec_write_end = 1'b1;
        else bus.sd_sec_read_end = 1'b1;
        tick();
        bus.sd_sec_read_end = 1'b0; bus.sd_sec_write_end = 1'b0;
        @(negedge clk);
        check("end_done", bus.done, onehot(owner));
        check("end_busy", bus.busy, 1'b1);
        @(negedge clk);
        check("idle_busy", bus.busy, 1'b0);
        if (is_wr) begin
            check("wreq_owner_count", c_wq[owner] - wq_b[owner], nbytes);
            check("wreq_other_count", c_wq[1-owner] - wq_b[1-owner], 0);
        end else begin
            check("rvalid_owner_count", c_rv[owner] - rv_b[owner], nbytes);
            check("rvalid_other_count", c_rv[1-owner] - rv_b[1-owner], 0);
        end
    endtask

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int w;
        int n;
        int order [4];
        int exp_order [4];
        logic [31:0] a;
`ifdef SD_SEC_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        bus.req = 2'b00; bus.wr = 2'b00; bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0; bus.sd_init_done = 1'b0;
        bus.sd_sec_read_data = '0; bus.sd_sec_read_data_valid = 1'b0;
        bus.sd_sec_read_end = 1'b0; bus.sd_sec_write_data_req = 1'b0;
        bus.sd_sec_write_end = 1'b0;

        // 1: reset, requests ignored before init, 2-cycle grant after init
        repeat (3) @(negedge clk);
        check("reset_ack", bus.ack, 2'b00);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_read", bus.sd_sec_read, 1'b0);
        tick();
        rst = 1'b0; bus.req = 2'b01; bus.wr = 2'b00; bus.addr0 = 32'd5;
        repeat (5) begin
            @(negedge clk);
            check("t1_no_ack_before_init", bus.ack, 2'b00);
        end
        tick();
        bus.sd_init_done = 1'b1;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.ack !== 2'b00) break;
        end
        // init cycle, idle cycle, then the ack cycle
        check("t1_grant_latency", n, 3);
        check("t1_ack", bus.ack, 2'b01);
        check("t1_read", bus.sd_sec_read, 1'b1);
        check("t1_read_addr", bus.sd_sec_read_addr, 32'd5);
        tick();
        bus.req = 2'b00;
        serve(0, 8, -1);

        // 2: full sector read by requester 1
        a = $urandom;
        request(2'b10, 2'b00, 32'h0, a, 1'b0, w);
        check("t2_winner", w, 1);
        check("t2_read_addr", bus.sd_sec_read_addr, a);
        serve(1, 512, -1);

        // 4: both requesting back to back (history: requester 1 finished last)
        for (int g = 0; g < 4; g++) begin
            request(2'b11, 2'b00, 32'h100 + g, 32'h200 + g, (g < 3), w);
            order[g] = w;
            serve(w, 4, -1);
        end
        for (int g = 0; g < 4; g++) check("t4_grant_order", order[g], exp_order[g]);

        // 3: full sector write by requester 0
        a = $urandom;
        request(2'b01, 2'b01, a, 32'h0, 1'b0, w);
        check("t3_winner", w, 0);
        check("t3_write_addr", bus.sd_sec_write_addr, a);
        serve(0, 512, -1);

        // 5: init lost after 100 read bytes, then recovery
        request(2'b01, 2'b00, 32'h55, 32'h0, 1'b0, w);
        serve(w, 512, 100);
        tick();
        bus.sd_init_done = 1'b1;
        tick(); tick();
        request(2'b01, 2'b00, 32'h56, 32'h0, 1'b0, w);
        serve(w, 16, -1);

        // 6: asynchronous reset in the middle of a write
        request(2'b01, 2'b01, 32'h1234, 32'h0, 1'b0, w);
        repeat (3) begin
            bus.sd_sec_write_data_req = 1'b1;
            bus.wdata0 = 8'($urandom);
            tick();
        end
        check("t6_writing", bus.sd_sec_write, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_write", bus.sd_sec_write, 1'b0);
        check("t6_rst_waddr", bus.sd_sec_write_addr, 32'h0);
        check("t6_rst_busy", bus.busy, 1'b0);
        check("t6_rst_wreq", bus.wreq, 2'b00);
        check("t6_rst_status", {bus.ack, bus.done, bus.err}, 6'b0);
        bus.sd_sec_write_data_req = 1'b0;
        bus.sd_init_done = 1'b0;
        tick(); tick();
        rst = 1'b0; bus.req = 2'b01; bus.wr = 2'b00; bus.addr0 = 32'd77;
        repeat (4) begin
            @(negedge clk);
            check("t6_no_ack_before_init", bus.ack, 2'b00);
        end
        tick();
        bus.sd_init_done = 1'b1;
        request(2'b01, 2'b00, 32'd77, 32'h0, 1'b0, w);
        check("t6_winner", w, 0);
        check("t6_read_addr", bus.sd_sec_read_addr, 32'd77);
        serve(0, 4, -1);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            int nb;
            int drop;
            if ($urandom_range(0, 3) == 0) begin
                bus.sd_sec_read_end = ($urandom_range(0, 1) == 1);
                bus.sd_sec_write_end = ~bus.sd_sec_read_end;
                tick();
                bus.sd_sec_read_end = 1'b0; bus.sd_sec_write_end = 1'b0;
            end
            request(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom, 1'b0, w);
            nb = $urandom_range(1, 12);
            drop = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nb - 1) : -1;
            serve(w, nb, drop);
            if (drop >= 0) begin
                tick();
                bus.sd_init_done = 1'b1;
                tick(); tick();
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sd_sec_arbiter.md
Name: sd_sec_arbiter

Overview:
Two-port arbiter that shares the single sd_card_top sector interface (read/write, 512-byte sectors) between two requesters, e.g. a logger writer and a playback reader. It accepts sector commands, grants one owner per sector, and drives sd_sec_read/sd_sec_write plus the address for that owner. It steers per-byte read data and write data requests to and from the owner, and reports completion or abort. It sits between the user logic and sd_card_top in the sys_clk (50 MHz) domain.

Parameters:
ADDR_W, 32, sector address width
DATA_W, 8, sector byte width

Ports:
clk  in  1  system clock (sys_clk, 50 MHz)
rst  in  1  asynchronous active-high reset
req  in  2  per-requester command request; hold until ack
wr  in  2  per-requester direction, 1=write sector, 0=read sector
addr0  in  ADDR_W  requester 0 sector address
addr1  in  ADDR_W  requester 1 sector address
wdata0  in  DATA_W  requester 0 write byte
wdata1  in  DATA_W  requester 1 write byte
ack  out  2  one-cycle grant pulse, command accepted
done  out  2  one-cycle completion pulse
err  out  2  one-cycle abort pulse (init lost mid-sector)
rdata  out  DATA_W  read byte, broadcast copy of sd_sec_read_data
rvalid  out  2  read byte valid, owner only
wreq  out  2  write byte request, owner only
busy  out  1  high while a sector is owned (S_READ, S_WRITE, S_DONE)
sd_init_done  in  1  from sd_card_top
sd_sec_read  out  1  to sd_card_top
sd_sec_read_addr  out  ADDR_W  to sd_card_top
sd_sec_read_data  in  DATA_W  from sd_card_top
sd_sec_read_data_valid  in  1  from sd_card_top
sd_sec_read_end  in  1  from sd_card_top
sd_sec_write  out  1  to sd_card_top
sd_sec_write_addr  out  ADDR_W  to sd_card_top
sd_sec_write_data  out  DATA_W  to sd_card_top
sd_sec_write_data_req  in  1  from sd_card_top
sd_sec_write_end  in  1  from sd_card_top

Behaviour:
- Reset: state=S_WAIT_INIT, owner=0, last=1. All registered outputs are 0: ack, done, err, sd_sec_read, sd_sec_write, both addresses, busy.
- S_WAIT_INIT: go to S_IDLE when sd_init_done=1. Requests are ignored (no ack).
- S_IDLE: if any req bit is set, choose a winner, then on the next edge:
  - owner<=winner; ack[winner]=1 for one cycle.
  - Latch the winner's addr into sd_sec_read_addr or sd_sec_write_addr (the other address holds its value).
  - If wr[winner]=1: state=S_WRITE and sd_sec_write=1. Otherwise: state=S_READ and sd_sec_read=1.
  - Grant latency is 1 cycle from req being sampled.
- S_READ: sd_sec_read stays high. On the edge where sd_sec_read_end=1: sd_sec_read<=0, done[owner]<=1, state=S_DONE.
- S_WRITE: same as S_READ, using sd_sec_write and sd_sec_write_end.
- S_DONE: one cycle. Then last<=owner and state=S_IDLE. Minimum gap between consecutive sector commands: 2 idle cycles.
- Steering (combinational):
  - rvalid[i] = sd_sec_read_data_valid & (state==S_READ) & (owner==i).
  - wreq[i] = sd_sec_write_data_req & (state==S_WRITE) & (owner==i).
  - sd_sec_write_data = owner ? wdata1 : wdata0. The owner must present the byte by the cycle after wreq.
  - The non-owner never sees rvalid or wreq.
- Requester must drop req in the cycle after ack. A req still high in S_IDLE after S_DONE is treated as a new command.
- wr and addr are sampled only on the granting edge. Later changes have no effect.
- sd_init_done falling in S_READ, S_WRITE or S_DONE:
  - Next edge: sd_sec_read=0, sd_sec_write=0, err[owner]=1 (one cycle), no done, state=S_WAIT_INIT.
  - last is unchanged.
- sd_sec_read_end or sd_sec_write_end arriving outside its matching state: ignored.
- Simultaneous end and init loss: init loss wins (err, not done).
- Illegal state encoding: go to S_WAIT_INIT.

Optional Feature:
- Macro: SD_SEC_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On a tie, the winner is the requester that is not last. Requester 0 wins the first tie after reset.
- Undefined: fixed priority. Requester 0 always wins a tie. The last register may be optimised away.
- Single-request behaviour is identical in both modes.

Test Plan:
1. rst high, then release with sd_init_done=0 and req=2'b01 -> ack stays 0. sd_init_done rises -> ack[0] pulses 2 cycles later, sd_sec_read=1, sd_sec_read_addr=addr0=32'd5.
2. Read by requester 1: model supplies 512 valid bytes 0x00..0xFF,0x00..0xFF, then end -> rvalid[1] high exactly 512 cycles, rvalid[0] never, done[1] one pulse, busy low 2 cycles after end.
3. Write by requester 0 with wdata0 = byte index -> sd_sec_write_data follows wdata0, wreq[0] pulses 512 times, wreq[1]=0, done[0] one pulse, sd_sec_write_addr=addr0.
4. req=2'b11 held continuously (re-raised after each ack) for 4 grants -> ROUND_ROBIN_EN: grants 0,1,0,1. Without the macro: 0,0,0,0.
5. sd_init_done drops after 100 read bytes -> next edge sd_sec_read=0, err[owner]=1, done=0, state S_WAIT_INIT. Restore init, reissue -> normal completion.
6. rst asserted mid-write -> all outputs 0 asynchronously. After release, no ack until sd_init_done=1.
